macc_drain: RTL and testbench
=============================

# macc_drain

Result-drain unit for a row of MAC lanes. On a capture strobe it snapshots every lane's 19-bit signed accumulator into a holding bank, freeing the MACs to clear and start the next tile. It then serializes the lanes, lane 0 first, onto a valid/ready stream toward the output buffer. It is the read side of the MAC accumulator interface, and sits between the MAC array and the result writeback path.

## Interface
- NUM_MACS, 4, number of accumulator lanes captured per strobe (≥2)
- ACC_W, 19, accumulator width per lane, signed
- IDX_W, $clog2(NUM_MACS), lane index width
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- capture  in  1  one-cycle strobe: snapshot macc_in
- macc_in  in  NUM_MACS*ACC_W  packed accumulators; lane k at bits [k*ACC_W +: ACC_W]
- shift  in  4  requant right-shift amount (used only with MACC_DRAIN_REQUANT_EN), sampled at capture
- cap_ready  out  1  capture will be accepted this cycle
- busy  out  1  holding bank occupied (state DRAIN)
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts
- out_data  out  ACC_W  lane value (signed)
- out_idx  out  IDX_W  lane number of out_data
- out_last  out  1  high with the final lane (idx NUM_MACS-1)
- drop_err  out  1  sticky: a capture arrived while cap_ready=0

## Operation
- FSM states: IDLE, DRAIN.
- IDLE: cap_ready=1. capture → latch all lanes and shift, idx←0, → DRAIN.
- DRAIN: out_valid=1, out_data=bank[idx] (requantized if enabled), out_last=(idx==NUM_MACS-1).
  - Handshake when out_valid&&out_ready. Not last: idx←idx+1. Last: → IDLE.
  - Without a handshake, out_data, out_idx and out_last hold stable.
- cap_ready = IDLE, or (DRAIN && out_last && out_ready). This gives back-to-back tiles with no bubble. On a simultaneous final handshake and capture, the bank reloads, idx←0 and the FSM stays in DRAIN.
- capture while cap_ready=0: ignored, and the bank is unchanged. drop_err←1 and stays set until reset.
- busy = (state==DRAIN).
- Reset (rst_n=0 at an edge), including mid-drain: state IDLE, out_valid=0, out_data=0, out_idx=0, out_last=0, drop_err=0, bank cleared. Pending lanes are discarded.

## Timing
- Latency: capture at edge N → out_valid=1 after edge N (first beat visible in cycle N+1).
- Throughput: one lane per cycle under continuous out_ready. A tile takes NUM_MACS cycles.
- Outputs come from registers or the FSM. out_data may pass through combinational requant logic from the registered bank and registered shift.
- No combinational path from out_ready to out_valid. cap_ready depends combinationally on out_ready.

## Configuration
- MACC_DRAIN_REQUANT_EN defined:
  - out_data = sign-extended sat8((acc + rnd) >>> shift), where rnd = shift ? 1<<(shift-1) : 0.
  - sat8 clamps to [-128, 127].
  - The add uses ACC_W+1 bits, so there is no overflow.
- Undefined: out_data = raw accumulator; the shift port is ignored.

## Structure
- Shared package gemm_pkg: ACC_W=19, OPERAND_W=8, drain state enum, and the INT8_MIN/INT8_MAX constants.
- One sub-module, macc_requant: combinational round/shift/saturate, instantiated only under MACC_DRAIN_REQUANT_EN.

## Test plan
- Basic drain: NUM_MACS=4, lanes {10,-20,30,-40}, out_ready=1 → beats idx 0..3 with values 10,-20,30,-40 on consecutive cycles; out_last only on idx 3; then out_valid=0.
- Backpressure: out_ready low for 3 cycles on idx 1 → out_data=-20 and idx=1 held stable; the stream resumes without loss or duplication.
- Back-to-back: second capture {1,2,3,4} in the cycle of the last handshake → next cycle out_valid=1, idx=0, data=1; no idle gap.
- Drop: capture during idx 1 of a drain → ignored, original lanes complete, drop_err=1 and sticky until rst_n=0.
- Reset mid-drain: rst_n=0 at idx 2 → next cycle out_valid=0, busy=0, drop_err=0, cap_ready=1.
- Requant (macro on): lanes {300,-5,-300,3}, shift=1 → 127, -2, -128, 2.

Source files
------------

// File: rtl/gemm_pkg.sv
// gemm_pkg: definitions shared by the GEMM datapath blocks.
//   ACC_W      accumulator width per MAC lane (signed)
//   OPERAND_W  int8 operand width
//   INT8_MIN / INT8_MAX  saturation bounds for requantized results
//   drain_state_e        state encoding of the result-drain FSM
package gemm_pkg;

   localparam int unsigned ACC_W     = 19;
   localparam int unsigned OPERAND_W = 8;

   localparam int INT8_MIN = -128;
   localparam int INT8_MAX = 127;

   typedef enum logic {
      IDLE,
      DRAIN
   } drain_state_e;

endpackage

// File: rtl/macc_requant.sv
// macc_requant: combinational round / arithmetic-shift / int8 saturate.
// Built only when MACC_DRAIN_REQUANT_EN is defined.
// Ports:
//   acc    in   W  signed accumulator value
//   shift  in   4  right-shift amount (round-half-up before shifting)
//   q      out  W  sat8((acc + rnd) >>> shift), sign-extended to W bits
module macc_requant
   import gemm_pkg::*;
#(
   parameter int unsigned W = ACC_W
) (
   input  logic signed [W-1:0] acc,
   input  logic        [3:0]   shift,
   output logic signed [W-1:0] q
);

   localparam logic signed [W:0] SAT_HI = INT8_MAX;
   localparam logic signed [W:0] SAT_LO = INT8_MIN;

   logic signed [W:0] rnd;
   logic signed [W:0] sum;
   logic signed [W:0] shifted;

   always_comb begin
      rnd = '0;
      if (shift != 4'd0) begin
         rnd[shift - 4'd1] = 1'b1;
      end
      // One guard bit keeps the rounding add from wrapping.
      sum     = {acc[W-1], acc} + rnd;
      shifted = sum >>> shift;
      if (shifted > SAT_HI) begin
         q = SAT_HI[W-1:0];
      end else if (shifted < SAT_LO) begin
         q = SAT_LO[W-1:0];
      end else begin
         q = shifted[W-1:0];
      end
   end

endmodule

// File: rtl/macc_drain.sv
// macc_drain: snapshots all MAC accumulators on a capture strobe and streams
// them out lane 0 first over a valid/ready interface.
// Optional feature macro: MACC_DRAIN_REQUANT_EN (int8 requant of each lane).
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   capture      one-cycle strobe, snapshot macc_in (and shift)
//   macc_in      packed accumulators, lane k at [k*ACC_W +: ACC_W]
//   shift        requant shift, sampled at capture (unused without requant)
//   cap_ready    capture is accepted this cycle
//   busy         holding bank occupied
//   out_valid / out_ready / out_data / out_idx / out_last  result stream
//   drop_err     sticky, set by a capture while cap_ready=0
module macc_drain #(
   parameter int unsigned NUM_MACS = 4,
   parameter int unsigned ACC_W    = gemm_pkg::ACC_W,
   parameter int unsigned IDX_W    = $clog2(NUM_MACS)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       capture,
   input  logic [NUM_MACS*ACC_W-1:0]  macc_in,
   input  logic [3:0]                 shift,
   output logic                       cap_ready,
   output logic                       busy,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic signed [ACC_W-1:0]    out_data,
   output logic [IDX_W-1:0]           out_idx,
   output logic                       out_last,
   output logic                       drop_err
);
   import gemm_pkg::*;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MACS - 1);

   drain_state_e            state;
   drain_state_e            state_nxt;
   logic [IDX_W-1:0]        idx;
   logic signed [ACC_W-1:0] bank [NUM_MACS];
   logic signed [ACC_W-1:0] lane_val;
   logic                    is_last;
   logic                    take;

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      out_valid = 1'b0;
      is_last   = 1'b0;
      cap_ready = 1'b0;
      take      = 1'b0;
      case (state)
         IDLE: begin
            cap_ready = 1'b1;
            take      = capture;
            if (take) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            is_last   = (idx == LAST_IDX);
            // Bank frees up in the same cycle its final lane is accepted.
            cap_ready = is_last && out_ready;
            take      = capture && cap_ready;
            if (is_last && out_ready && !take) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- holding bank / lane index ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx      <= '0;
         drop_err <= 1'b0;
         for (int unsigned k = 0; k < NUM_MACS; k++) begin
            bank[k] <= '0;
         end
      end else begin
         if (capture && !cap_ready) begin
            drop_err <= 1'b1;
         end
         if (take) begin
            idx <= '0;
            for (int unsigned k = 0; k < NUM_MACS; k++) begin
               bank[k] <= macc_in[k*ACC_W +: ACC_W];
            end
         end else if (out_valid && out_ready) begin
            // Return to lane 0 after the last beat so out_idx idles at 0.
            idx <= is_last ? '0 : idx + 1'b1;
         end
      end
   end

`ifdef MACC_DRAIN_REQUANT_EN
   logic [3:0] shift_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shift_q <= '0;
      end else if (take) begin
         shift_q <= shift;
      end
   end

   macc_requant #(
      .W (ACC_W)
   ) u_requant (
      .acc   (bank[idx]),
      .shift (shift_q),
      .q     (lane_val)
   );
`else
   logic unused_shift;
   assign unused_shift = ^shift;
   assign lane_val     = bank[idx];
`endif

   assign out_data = out_valid ? lane_val : '0;
   assign out_idx  = idx;
   assign out_last = is_last;

endmodule

// File: tb/tb_macc_drain.sv
// tb_macc_drain: self-checking bench for macc_drain (NUM_MACS=4).
// Directed scenarios plus a randomized run checked against a queue-based
// model of the expected output beats. Honours MACC_DRAIN_REQUANT_EN.
module tb_macc_drain;

   localparam int NUM_MACS = 4;
   localparam int ACC_W    = 19;
   localparam int IDX_W    = 2;
   localparam int BW       = ACC_W + IDX_W + 2;

   logic                      clk = 1'b0;
   logic                      rst_n;
   logic                      capture;
   logic [NUM_MACS*ACC_W-1:0] macc_in;
   logic [3:0]                shift;
   logic                      cap_ready;
   logic                      busy;
   logic                      out_valid;
   logic                      out_ready;
   logic [ACC_W-1:0]          out_data;
   logic [IDX_W-1:0]          out_idx;
   logic                      out_last;
   logic                      drop_err;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int data;
      int idx;
      bit last;
   } beat_t;

   macc_drain #(
      .NUM_MACS (NUM_MACS),
      .ACC_W    (ACC_W),
      .IDX_W    (IDX_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .capture   (capture),
      .macc_in   (macc_in),
      .shift     (shift),
      .cap_ready (cap_ready),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .drop_err  (drop_err)
   );

   always #5 clk = ~clk;

   // Expected lane value from the arithmetic definition of requantization.
   function automatic int model(input int acc, input int sh);
`ifdef MACC_DRAIN_REQUANT_EN
      longint v;
      longint d;
      d = longint'(1) << sh;
      v = acc;
      if (sh > 0) v = v + d / 2;
      if (v >= 0) v = v / d;
      else        v = -((-v + d - 1) / d);
      if (v > 127)  v = 127;
      if (v < -128) v = -128;
      return int'(v);
`else
      if (sh < 0) return 0;
      return acc;
`endif
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int l0, input int l1, input int l2, input int l3, input int sh);
      int v[4];
      v = '{l0, l1, l2, l3};
      for (int k = 0; k < 4; k++) macc_in[k*ACC_W +: ACC_W] = ACC_W'(v[k]);
      shift = 4'(sh);
   endtask

   task automatic test_reset;
      rst_n = 1'b0; capture = 1'b0; out_ready = 1'b0; macc_in = '0; shift = '0;
      tick; tick;
      checks++;
      if ({out_valid, busy, out_last, drop_err, cap_ready, out_idx, out_data} !==
          {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, {IDX_W{1'b0}}, {ACC_W{1'b0}}}) begin
         errors++;
         $display("FAIL reset_state got v=%b b=%b l=%b e=%b cr=%b idx=%0d d=%0d want 0,0,0,0,1,0,0",
                  out_valid, busy, out_last, drop_err, cap_ready, out_idx, out_data);
      end
      rst_n = 1'b1;
      tick;
      checks++;
      if ({out_valid, busy, cap_ready} !== 3'b001) begin
         errors++;
         $display("FAIL idle_after_reset got v=%b b=%b cr=%b want 0,0,1", out_valid, busy, cap_ready);
      end
   endtask

   task automatic test_basic;
      int v[4];
      logic [BW-1:0] want;
      v = '{10, -20, 30, -40};
      load(v[0], v[1], v[2], v[3], 0);
      capture = 1'b1; out_ready = 1'b1;
      tick;
      capture = 1'b0;
      for (int i = 0; i < 4; i++) begin
         want = {1'b1, IDX_W'(i), (i == 3), ACC_W'(model(v[i], 0))};
         checks++;
         if ({out_valid, out_idx, out_last, out_data} !== want) begin
            errors++;
            $display("FAIL basic_beat%0d got=%h want=%h", i, {out_valid, out_idx, out_last, out_data}, want);
         end
         tick;
      end
      checks++;
      if ({out_valid, out_last, busy} !== 3'b000) begin
         errors++;
         $display("FAIL basic_end got v=%b l=%b b=%b want 0,0,0", out_valid, out_last, busy);
      end
   endtask

   task automatic test_backpressure;
      int v[4];
      logic [BW-1:0] want;
      v = '{21, -20, -7, 100};
      load(v[0], v[1], v[2], v[3], 0);
      capture = 1'b1; out_ready = 1'b1;
      tick;
      capture = 1'b0;
      tick;
      out_ready = 1'b0;
      for (int r = 0; r < 3; r++) begin
         want = {1'b1, IDX_W'(1), 1'b0, ACC_W'(model(v[1], 0))};
         checks++;
         if ({out_valid, out_idx, out_last, out_data} !== want) begin
            errors++;
            $display("FAIL stall_hold%0d got=%h want=%h", r, {out_valid, out_idx, out_last, out_data}, want);
         end
         tick;
      end
      out_ready = 1'b1;
      for (int i = 1; i < 4; i++) begin
         want = {1'b1, IDX_W'(i), (i == 3), ACC_W'(model(v[i], 0))};
         checks++;
         if ({out_valid, out_idx, out_last, out_data} !== want) begin
            errors++;
            $display("FAIL stall_resume%0d got=%h want=%h", i, {out_valid, out_idx, out_last, out_data}, want);
         end
         tick;
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL stall_end got out_valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_back_to_back;
      int a[4];
      int b[4];
      logic [BW-1:0] want;
      a = '{5, 6, 7, 8};
      b = '{1, 2, 3, 4};
      load(a[0], a[1], a[2], a[3], 0);
      capture = 1'b1; out_ready = 1'b1;
      tick;
      capture = 1'b0;
      for (int i = 0; i < 4; i++) begin
         want = {1'b1, IDX_W'(i), (i == 3), ACC_W'(model(a[i], 0))};
         checks++;
         if ({out_valid, out_idx, out_last, out_data} !== want) begin
            errors++;
            $display("FAIL b2b_first%0d got=%h want=%h", i, {out_valid, out_idx, out_last, out_data}, want);
         end
         if (i == 3) begin
            load(b[0], b[1], b[2], b[3], 0);
            capture = 1'b1;
         end
         #1;
         checks++;
         if (cap_ready !== (i == 3)) begin
            errors++;
            $display("FAIL b2b_cap_ready%0d got=%b want=%b", i, cap_ready, (i == 3));
         end
         tick;
      end
      capture = 1'b0;
      for (int i = 0; i < 4; i++) begin
         want = {1'b1, IDX_W'(i), (i == 3), ACC_W'(model(b[i], 0))};
         checks++;
         if ({out_valid, out_idx, out_last, out_data} !== want) begin
            errors++;
            $display("FAIL b2b_second%0d got=%h want=%h", i, {out_valid, out_idx, out_last, out_data}, want);
         end
         tick;
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_end got out_valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_drop;
      int v[4];
      logic [BW-1:0] want;
      v = '{11, -12, 13, -14};
      load(v[0], v[1], v[2], v[3], 0);
      capture = 1'b1; out_ready = 1'b1;
      tick;
      capture = 1'b0;
      for (int i = 0; i < 4; i++) begin
         want = {1'b1, IDX_W'(i), (i == 3), ACC_W'(model(v[i], 0))};
         checks++;
         if ({out_valid, out_idx, out_last, out_data} !== want) begin
            errors++;
            $display("FAIL drop_beat%0d got=%h want=%h", i, {out_valid, out_idx, out_last, out_data}, want);
         end
         if (i == 1) begin
            load(99, 98, 97, 96, 0);
            capture = 1'b1;
         end
         tick;
         capture = 1'b0;
         checks++;
         if (drop_err !== (i >= 1)) begin
            errors++;
            $display("FAIL drop_err_at%0d got=%b want=%b", i, drop_err, (i >= 1));
         end
      end
      tick; tick; tick;
      checks++;
      if ({out_valid, drop_err} !== 2'b01) begin
         errors++;
         $display("FAIL drop_sticky got v=%b err=%b want 0,1", out_valid, drop_err);
      end
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      checks++;
      if (drop_err !== 1'b0) begin
         errors++;
         $display("FAIL drop_clear got=%b want 0", drop_err);
      end
   endtask

   task automatic test_reset_mid;
      load(40, 41, 42, 43, 0);
      capture = 1'b1; out_ready = 1'b1;
      tick;
      tick;
      capture = 1'b0;
      tick;
      checks++;
      if ({out_valid, out_idx, drop_err} !== {1'b1, IDX_W'(2), 1'b1}) begin
         errors++;
         $display("FAIL midrst_pre got v=%b idx=%0d err=%b want 1,2,1", out_valid, out_idx, drop_err);
      end
      rst_n = 1'b0;
      tick;
      checks++;
      if ({out_valid, busy, drop_err, cap_ready, out_idx, out_data} !==
          {1'b0, 1'b0, 1'b0, 1'b1, {IDX_W{1'b0}}, {ACC_W{1'b0}}}) begin
         errors++;
         $display("FAIL midrst_state got v=%b b=%b err=%b cr=%b idx=%0d d=%0d want 0,0,0,1,0,0",
                  out_valid, busy, drop_err, cap_ready, out_idx, out_data);
      end
      rst_n = 1'b1;
      tick;
      checks++;
      if ({out_valid, busy} !== 2'b00) begin
         errors++;
         $display("FAIL midrst_discard got v=%b b=%b want 0,0", out_valid, busy);
      end
   endtask

   task automatic test_requant;
      int v[4];
      int e[4];
      logic [BW-1:0] want;
      v = '{300, -5, -300, 3};
`ifdef MACC_DRAIN_REQUANT_EN
      e = '{127, -2, -128, 2};
`else
      e = '{300, -5, -300, 3};
`endif
      load(v[0], v[1], v[2], v[3], 1);
      capture = 1'b1; out_ready = 1'b1;
      tick;
      capture = 1'b0;
      shift = 4'd9;
      for (int i = 0; i < 4; i++) begin
         want = {1'b1, IDX_W'(i), (i == 3), ACC_W'(e[i])};
         checks++;
         if ({out_valid, out_idx, out_last, out_data} !== want) begin
            errors++;
            $display("FAIL requant_beat%0d got=%h want=%h", i, {out_valid, out_idx, out_last, out_data}, want);
         end
         tick;
      end
   endtask

   task automatic test_random;
      beat_t q[$];
      bit exp_drop;
      logic [BW-1:0] want;
      rst_n = 1'b0; capture = 1'b0;
      tick;
      rst_n = 1'b1;
      exp_drop = 1'b0;
      for (int c = 0; c < 400; c++) begin
         int  lanes[4];
         int  sh;
         bit  exp_cap;
         out_ready = ($urandom_range(0, 3) != 0);
         capture   = ($urandom_range(0, 3) == 0);
         sh        = int'($urandom_range(0, 15));
         for (int k = 0; k < 4; k++)
            lanes[k] = int'($urandom_range(0, (1 << ACC_W) - 1)) - (1 << (ACC_W - 1));
         load(lanes[0], lanes[1], lanes[2], lanes[3], sh);
         #1;
         // The bank is free when nothing is pending or its final lane leaves now.
         exp_cap = (q.size() == 0) || (q.size() == 1 && out_ready);
         checks++;
         if ({out_valid, busy, cap_ready} !== {q.size() > 0, q.size() > 0, exp_cap}) begin
            errors++;
            $display("FAIL rand_ctrl cyc=%0d got v=%b b=%b cr=%b want %b,%b,%b", c,
                     out_valid, busy, cap_ready, q.size() > 0, q.size() > 0, exp_cap);
         end
         if (q.size() > 0) begin
            want = {1'b1, IDX_W'(q[0].idx), q[0].last, ACC_W'(q[0].data)};
            checks++;
            if ({out_valid, out_idx, out_last, out_data} !== want) begin
               errors++;
               $display("FAIL rand_beat cyc=%0d got=%h want=%h", c, {out_valid, out_idx, out_last, out_data}, want);
            end
            if (out_ready) void'(q.pop_front());
         end
         if (capture) begin
            if (exp_cap) begin
               for (int k = 0; k < 4; k++) q.push_back('{model(lanes[k], sh), k, (k == 3)});
            end else begin
               exp_drop = 1'b1;
            end
         end
         tick;
         checks++;
         if (drop_err !== exp_drop) begin
            errors++;
            $display("FAIL rand_drop cyc=%0d got=%b want=%b", c, drop_err, exp_drop);
         end
      end
      capture = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 6 && q.size() > 0; c++) begin
         want = {1'b1, IDX_W'(q[0].idx), q[0].last, ACC_W'(q[0].data)};
         checks++;
         if ({out_valid, out_idx, out_last, out_data} !== want) begin
            errors++;
            $display("FAIL rand_flush got=%h want=%h", {out_valid, out_idx, out_last, out_data}, want);
         end
         void'(q.pop_front());
         tick;
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rand_end got out_valid=%b want 0", out_valid);
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_backpressure;
      test_back_to_back;
      test_drop;
      test_reset_mid;
      test_requant;
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
